// File: rtl/mips32_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips32_arb_pkg
//  Description : Shared types and constants for the MIPS32 memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips32_arb_pkg;

    // Width of the latency and starvation counters (both cover 1..15).
    localparam int c_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_IF = 2'd0,
        REQ_DM = 2'd1,
        REQ_LD = 2'd2
    } req_id_t;

endpackage
`default_nettype wire

// File: rtl/mips32_arb_prio.sv
`default_nettype none
// ============================================================================
//  Module      : mips32_arb_prio
//  Description : Combinational winner select, LD > DM > IF, with optional
//                promotion of IF above DM when i_force_if is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips32_arb_prio
    import mips32_arb_pkg::*;
(
    input  logic    i_if_req,
    input  logic    i_dm_req,
    input  logic    i_ld_req,
    input  logic    i_force_if,
    output logic    o_valid,
    output req_id_t o_winner
);

    always_comb begin
        o_valid  = i_if_req | i_dm_req | i_ld_req;
        o_winner = REQ_IF;
        if (i_ld_req) begin
            o_winner = REQ_LD;
        end else if (i_force_if && i_if_req) begin
            o_winner = REQ_IF;
        end else if (i_dm_req) begin
            o_winner = REQ_DM;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips32_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mips32_mem_arbiter
//  Description : Shares one single-port word memory between fetch (IF), data
//                (DM) and loader (LD) ports with a fixed-latency access cycle.
//                Optional IF starvation guard: MIPS32_ARB_STARVE_GUARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips32_mem_arbiter
    import mips32_arb_pkg::*;
#(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk1,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    input  logic          cpu_halted,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [c_CNT_W-1:0] c_LAT     = MEM_LAT[c_CNT_W-1:0];
    localparam logic [c_CNT_W-1:0] c_LAT_END = 1;

    if ((MEM_LAT < 1) || (MEM_LAT > 15)) begin : g_bad_mem_lat
        $error("mips32_mem_arbiter: MEM_LAT must be in 1..15");
    end
    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_starve_limit
        $error("mips32_mem_arbiter: STARVE_LIMIT must be in 1..15");
    end

    arb_state_t         r_state,  w_nxt_state;
    req_id_t            r_id,     w_nxt_id;
    logic               r_we,     w_nxt_we;
    logic [AW-1:0]      r_addr,   w_nxt_addr;
    logic [DW-1:0]      r_wdata,  w_nxt_wdata;
    logic [c_CNT_W-1:0] r_lat,    w_nxt_lat;
    logic [DW-1:0]      r_cap,    w_nxt_cap;
    logic [2:0]         r_gnt,    w_nxt_gnt;
    logic [2:0]         r_rvalid, w_nxt_rvalid;
    logic [DW-1:0]      r_if_rdata, w_nxt_if_rdata;
    logic [DW-1:0]      r_dm_rdata, w_nxt_dm_rdata;
    logic [DW-1:0]      r_ld_rdata, w_nxt_ld_rdata;

    logic               w_ld_qual;
    logic               w_force_if;
    logic               w_req_valid;
    req_id_t            w_winner;

    // The loader may only touch memory while the pipeline is halted.
    assign w_ld_qual = ld_req & cpu_halted;

    mips32_arb_prio u_prio (
        .i_if_req   (if_req),
        .i_dm_req   (dm_req),
        .i_ld_req   (w_ld_qual),
        .i_force_if (w_force_if),
        .o_valid    (w_req_valid),
        .o_winner   (w_winner)
    );

`ifdef MIPS32_ARB_STARVE_GUARD_EN
    localparam logic [c_CNT_W-1:0] c_STARVE_LIMIT = STARVE_LIMIT[c_CNT_W-1:0];

    logic [c_CNT_W-1:0] r_starve, w_nxt_starve;

    assign w_force_if = (r_starve >= c_STARVE_LIMIT);

    // Count IF losses at arbitration; saturate so the force flag never wraps.
    always_comb begin
        w_nxt_starve = r_starve;
        if ((r_state == IDLE) && w_req_valid) begin
            if (w_winner == REQ_IF) begin
                w_nxt_starve = '0;
            end else if (if_req && (r_starve != '1)) begin
                w_nxt_starve = r_starve + 1'b1;
            end
        end
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else begin
            r_starve <= w_nxt_starve;
        end
    end
`else
    assign w_force_if = 1'b0;
`endif

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_id       = r_id;
        w_nxt_we       = r_we;
        w_nxt_addr     = r_addr;
        w_nxt_wdata    = r_wdata;
        w_nxt_lat      = r_lat;
        w_nxt_cap      = r_cap;
        w_nxt_gnt      = '0;
        w_nxt_rvalid   = '0;
        w_nxt_if_rdata = r_if_rdata;
        w_nxt_dm_rdata = r_dm_rdata;
        w_nxt_ld_rdata = r_ld_rdata;
        case (r_state)
            IDLE: begin
                if (w_req_valid) begin
                    w_nxt_state         = ACCESS;
                    w_nxt_id            = w_winner;
                    w_nxt_lat           = c_LAT;
                    w_nxt_gnt[w_winner] = 1'b1;
                    case (w_winner)
                        REQ_LD: begin
                            w_nxt_we    = ld_we;
                            w_nxt_addr  = ld_addr;
                            w_nxt_wdata = ld_wdata;
                        end
                        REQ_DM: begin
                            w_nxt_we    = dm_we;
                            w_nxt_addr  = dm_addr;
                            w_nxt_wdata = dm_wdata;
                        end
                        default: begin
                            w_nxt_we    = 1'b0;
                            w_nxt_addr  = if_addr;
                            w_nxt_wdata = '0;
                        end
                    endcase
                end
            end
            ACCESS: begin
                w_nxt_lat = r_lat - 1'b1;
                if (r_lat == c_LAT_END) begin
                    w_nxt_cap   = mem_rdata;
                    w_nxt_state = RESP;
                end
            end
            RESP: begin
                w_nxt_rvalid[r_id] = 1'b1;
                w_nxt_state        = IDLE;
                // A write returns an all-zero acknowledge word.
                case (r_id)
                    REQ_LD:  w_nxt_ld_rdata = r_we ? '0 : r_cap;
                    REQ_DM:  w_nxt_dm_rdata = r_we ? '0 : r_cap;
                    default: w_nxt_if_rdata = r_we ? '0 : r_cap;
                endcase
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_id       <= REQ_IF;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_lat      <= '0;
            r_cap      <= '0;
            r_gnt      <= '0;
            r_rvalid   <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_ld_rdata <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_id       <= w_nxt_id;
            r_we       <= w_nxt_we;
            r_addr     <= w_nxt_addr;
            r_wdata    <= w_nxt_wdata;
            r_lat      <= w_nxt_lat;
            r_cap      <= w_nxt_cap;
            r_gnt      <= w_nxt_gnt;
            r_rvalid   <= w_nxt_rvalid;
            r_if_rdata <= w_nxt_if_rdata;
            r_dm_rdata <= w_nxt_dm_rdata;
            r_ld_rdata <= w_nxt_ld_rdata;
        end
    end

    assign if_gnt    = r_gnt[REQ_IF];
    assign dm_gnt    = r_gnt[REQ_DM];
    assign ld_gnt    = r_gnt[REQ_LD];
    assign if_rvalid = r_rvalid[REQ_IF];
    assign dm_rvalid = r_rvalid[REQ_DM];
    assign ld_rvalid = r_rvalid[REQ_LD];
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign ld_rdata  = r_ld_rdata;

    // Memory strobes are live only in ACCESS so they drop with the state.
    assign mem_en    = (r_state == ACCESS);
    assign mem_we    = mem_en & r_we;
    assign mem_addr  = mem_en ? r_addr  : '0;
    assign mem_wdata = mem_en ? r_wdata : '0;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mips32_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips32_mem_arbiter
//  Description : Directed and randomized self-checking bench for the arbiter
//                against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips32_mem_arbiter;

    localparam int AW           = 10;
    localparam int DW           = 32;
    localparam int MEM_LAT      = 2;
    localparam int STARVE_LIMIT = 4;
`ifdef MIPS32_ARB_STARVE_GUARD_EN
    localparam bit c_STARVE_EN = 1'b1;
`else
    localparam bit c_STARVE_EN = 1'b0;
`endif

    logic          clk1 = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_halted = 1'b0;
    logic          rq  [3];
    logic          rwe [3];
    logic [AW-1:0] rad [3];
    logic [DW-1:0] rwd [3];

    logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, ld_gnt, ld_rvalid;
    logic [DW-1:0] if_rdata, dm_rdata, ld_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [2:0]    gnt_vec, rv_vec;
    logic [DW-1:0] rd_port [3];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk1 = ~clk1;

    mips32_mem_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk1(clk1), .reset(reset),
        .if_req(rq[0]), .if_addr(rad[0]),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(rq[1]), .dm_we(rwe[1]), .dm_addr(rad[1]), .dm_wdata(rwd[1]),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .ld_req(rq[2]), .ld_we(rwe[2]), .ld_addr(rad[2]), .ld_wdata(rwd[2]),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .cpu_halted(cpu_halted),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    assign gnt_vec    = {ld_gnt, dm_gnt, if_gnt};
    assign rv_vec     = {ld_rvalid, dm_rvalid, if_rvalid};
    assign rd_port[0] = if_rdata;
    assign rd_port[1] = dm_rdata;
    assign rd_port[2] = ld_rdata;

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 5) return 32'h28020014;
        return 32'h1000_0000 + i * 32'h0000_0101;
    endfunction

    // Memory: read data is garbage until MEM_LAT cycles after mem_en rises.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            en_cnt;
    always @(posedge clk1) begin
        if (reset) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
            en_cnt <= 0;
        end else begin
            en_cnt <= mem_en ? en_cnt + 1 : 0;
            if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = (mem_en && !mem_we && en_cnt >= MEM_LAT - 1) ? mem[mem_addr] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic wait_any_gnt(output int w);
        w = 3;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (gnt_vec != 3'b000) begin
                chk("gnt_onehot", $countones(gnt_vec), 1);
                w = gnt_vec[2] ? 2 : (gnt_vec[1] ? 1 : 0);
                return;
            end
        end
        chk("gnt_timeout", 0, 1);
    endtask

    task automatic access(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, output int g_lat,
                          output int r_lat, output logic [DW-1:0] rd);
        rq[p] = 1'b1; rwe[p] = we; rad[p] = a; rwd[p] = wd;
        g_lat = 0; r_lat = 0; rd = '0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (gnt_vec[p]) begin g_lat = i; break; end
        end
        rq[p] = 1'b0;
        if (g_lat == 0) begin
            chk("access_gnt_timeout", 0, 1);
            return;
        end
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (rv_vec[p]) begin r_lat = i; rd = rd_port[p]; break; end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            if (!busy && gnt_vec == 3'b000 && rv_vec == 3'b000) return;
            tick();
        end
        chk("idle_timeout", 0, 1);
    endtask

    // Transaction-level reference model state for the random phase.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_rd [3];
    int            free_edge, g_edge, rv_edge, cur_id, starve;
    logic          inflight, have_g, cur_we;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] rv_data;

    initial begin
        int gl, rl, w, cnt, k, win, seen;
        logic [DW-1:0] rd;
        logic [2:0] exp_gnt, exp_rv, q;
        logic s_rq [3];
        logic s_we [3];
        logic [AW-1:0] s_ad [3];
        logic [DW-1:0] s_wd [3];
        logic s_halt, exp_busy, exp_en;

        for (int p = 0; p < 3; p++) begin
            rq[p] = 1'b0; rwe[p] = 1'b0; rad[p] = '0; rwd[p] = '0;
        end

        // Reset with a DM load pending; grant on first edge after release.
        rq[1] = 1'b1; rad[1] = 10'd5;
        repeat (3) tick();
        chk("rst_outs", |{gnt_vec, rv_vec, if_rdata, dm_rdata, ld_rdata,
                          mem_en, mem_we, mem_addr, mem_wdata, busy}, 0);
        @(negedge clk1);
        reset = 1'b0;
        access(1, 1'b0, 10'd5, '0, gl, rl, rd);
        chk("first_gnt_lat", gl, 1);
        chk("first_rv_lat", rl, MEM_LAT + 1);
        chk("first_rdata", rd, 32'h28020014);

        // Store then load through DM.
        wait_idle();
        access(1, 1'b1, 10'd3, 32'h0000001E, gl, rl, rd);
        chk("store_rv_lat", rl, MEM_LAT + 1);
        chk("store_ack", rd, 0);
        wait_idle();
        access(1, 1'b0, 10'd3, '0, gl, rl, rd);
        chk("load_rdata", rd, 32'h0000001E);
        wait_idle();

        // IF and DM contending.
        rq[0] = 1'b1; rad[0] = 10'd9;
        rq[1] = 1'b1; rwe[1] = 1'b0; rad[1] = 10'd7;
        for (int a = 1; a <= 6; a++) begin
            wait_any_gnt(w);
            chk("contend_arb", w, (c_STARVE_EN && a == STARVE_LIMIT + 1) ? 0 : 1);
            if (w == 0) rq[0] = 1'b0;
        end
        rq[1] = 1'b0;
        if (rq[0]) begin
            wait_any_gnt(w);
            chk("if_after_dm", w, 0);
            rq[0] = 1'b0;
        end
        chk("if_was_served", rq[0], 0);
        wait_idle();

        // Loader ignored until the pipeline halts, then beats DM.
        rq[2] = 1'b1; rwe[2] = 1'b0; rad[2] = 10'd5;
        cnt = 0;
        repeat (10) begin tick(); if (ld_gnt || busy) cnt++; end
        chk("ld_unqualified", cnt, 0);
        rq[1] = 1'b1; rwe[1] = 1'b0; rad[1] = 10'd3;
        cpu_halted = 1'b1;
        tick();
        chk("ld_first_gnt", gnt_vec, 3'b100);
        rq[2] = 1'b0;
        cpu_halted = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ld_rvalid) begin cnt = i; break; end
        end
        chk("ld_rv_lat_halt_fell", cnt, MEM_LAT + 1);
        chk("ld_rdata", ld_rdata, 32'h28020014);
        wait_any_gnt(w);
        chk("dm_after_ld", w, 1);
        rq[1] = 1'b0;
        wait_idle();

        // Asynchronous reset during an IF access drops it.
        rq[0] = 1'b1; rad[0] = 10'd2;
        wait_any_gnt(w);
        rq[0] = 1'b0;
        chk("if_gnt_before_rst", w, 0);
        #2;
        chk("busy_in_access", busy, 1);
        reset = 1'b1;
        #1;
        chk("async_rst_outs", |{gnt_vec, rv_vec, if_rdata, dm_rdata, ld_rdata,
                                mem_en, mem_we, mem_addr, mem_wdata, busy}, 0);
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        reset = 1'b0;
        seen = 0;
        repeat (MEM_LAT + 4) begin tick(); if (if_rvalid || busy) seen++; end
        chk("no_rv_after_rst", seen, 0);

        // Randomized phase against the transaction-level model.
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
        for (int p = 0; p < 3; p++) exp_rd[p] = '0;
        free_edge = 0; g_edge = 0; rv_edge = 0; cur_id = 0; starve = 0;
        inflight = 1'b0; have_g = 1'b0; cur_we = 1'b0; cur_addr = '0; rv_data = '0;
        k = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int p = 0; p < 3; p++) begin
                s_rq[p] = rq[p]; s_we[p] = rwe[p]; s_ad[p] = rad[p]; s_wd[p] = rwd[p];
            end
            s_halt = cpu_halted;
            tick();
            k++;
            exp_gnt = 3'b000;
            exp_rv  = 3'b000;
            if (inflight && k == rv_edge) begin
                exp_rv[cur_id] = 1'b1;
                exp_rd[cur_id] = rv_data;
                inflight = 1'b0;
            end
            q = {s_rq[2] & s_halt, s_rq[1], s_rq[0]};
            if (k >= free_edge && q != 3'b000) begin
                if (q[2]) win = 2;
                else if (c_STARVE_EN && starve >= STARVE_LIMIT && q[0]) win = 0;
                else if (q[1]) win = 1;
                else win = 0;
                if (win == 0) starve = 0;
                else if (q[0] && starve < 15) starve++;
                cur_id = win; cur_we = s_we[win] & (win != 0); cur_addr = s_ad[win];
                if (cur_we) begin
                    ref_mem[cur_addr] = s_wd[win];
                    rv_data = '0;
                end else begin
                    rv_data = ref_mem[cur_addr];
                end
                exp_gnt[win] = 1'b1;
                inflight = 1'b1; have_g = 1'b1; g_edge = k;
                rv_edge = k + MEM_LAT + 1; free_edge = k + MEM_LAT + 2;
            end
            exp_busy = have_g && k >= g_edge && k <= g_edge + MEM_LAT;
            exp_en   = have_g && k >= g_edge && k <  g_edge + MEM_LAT;
            chk("rnd_gnt", gnt_vec, exp_gnt);
            chk("rnd_rvalid", rv_vec, exp_rv);
            chk("rnd_if_rdata", if_rdata, exp_rd[0]);
            chk("rnd_dm_rdata", dm_rdata, exp_rd[1]);
            chk("rnd_ld_rdata", ld_rdata, exp_rd[2]);
            chk("rnd_busy", busy, exp_busy);
            chk("rnd_mem_en", mem_en, exp_en);
            if (exp_en) chk("rnd_mem_bus", {mem_we, mem_addr}, {cur_we, cur_addr});
            for (int p = 0; p < 3; p++) begin
                if (exp_gnt[p]) begin
                    rq[p] = 1'b0; rad[p] = AW'($urandom); rwd[p] = $urandom;
                end else if (!rq[p] && $urandom_range(0, 99) < 35) begin
                    rq[p]  = 1'b1;
                    rwe[p] = (p == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                    rad[p] = AW'($urandom_range(0, 15));
                    rwd[p] = $urandom;
                end
            end
            if ($urandom_range(0, 9) == 0) cpu_halted = ~cpu_halted;
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips32_mem_arbiter.md
Name: mips32_mem_arbiter

Overview:
- Single-clock arbiter sharing one single-port word memory between three requesters: pipeline instruction fetch (IF), pipeline data load/store (DM) and a program loader/debug port (LD).
- Sits between pipe_MIPS32's fetch and MEM stages and the unified memory array.
- Sequences each access through a fixed-latency memory cycle and returns data with a one-cycle valid pulse.

Parameters:
- AW, 10, word address width.
- DW, 32, data width.
- MEM_LAT, 2, memory read latency in cycles; legal range 1..15.
- STARVE_LIMIT, 4, consecutive lost IF arbitrations before forced IF grant; used only with the optional feature; legal range 1..15.

Ports:
- clk1  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  AW  fetch word address.
- if_gnt  out  1  one-cycle grant pulse.
- if_rvalid  out  1  one-cycle read-data valid.
- if_rdata  out  DW  fetch data.
- dm_req  in  1  data request; held until dm_gnt.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data word address.
- dm_wdata  in  DW  store data.
- dm_gnt  out  1  one-cycle grant pulse.
- dm_rvalid  out  1  load data valid or store acknowledge.
- dm_rdata  out  DW  load data.
- ld_req, ld_we, ld_addr, ld_wdata  in  1/1/AW/DW  loader request; same rules as the DM port.
- ld_gnt, ld_rvalid  out  1  loader grant and valid.
- ld_rdata  out  DW  loader read data.
- cpu_halted  in  1  pipeline HALTED flag; qualifies the loader.
- mem_en, mem_we  out  1  memory strobe and write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid MEM_LAT cycles after mem_en rises.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, latency counter 0, starvation counter 0. Reset asserted mid-access drops the access; no rvalid is produced for it afterwards.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any qualified request is present at an edge, register the winner's id, we, addr and wdata. Pulse the winner's gnt for one cycle, assert mem_en, load the counter with MEM_LAT and go to ACCESS. With no request, stay in IDLE.
- Qualified LD request: ld_req & cpu_halted. Priority order is LD > DM > IF.
- ACCESS: mem_en, mem_we, mem_addr and mem_wdata are driven from the registers and held stable. The counter decrements every cycle; at 1, capture mem_rdata and go to RESP.
- RESP: pulse the winner's rvalid for one cycle. rdata = captured word for a read, 0 for a write (the write acknowledge). Then return to IDLE.
- No re-arbitration occurs in RESP. Back-to-back accesses therefore cost MEM_LAT+2 cycles each.
- rdata outputs hold their last value between pulses; outputs of non-winners stay 0.
- Requests and addresses are sampled only in IDLE; changing them after gnt has no effect.
- Simultaneous requests: exactly one gnt is asserted; losers stay pending.
- cpu_halted falling while an LD access is in flight: the access completes normally.

Optional Feature:
- Macro: MIPS32_ARB_STARVE_GUARD_EN.
- Enabled: a 4-bit counter increments each time IF is pending in IDLE and loses. When the counter reaches STARVE_LIMIT, the next arbitration ranks IF above DM; LD stays highest. The counter clears whenever IF is granted.
- Disabled: strict fixed priority, counter logic absent.

Decomposition:
- Package mips32_arb_pkg holds:
  - the state enum: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - requester ids: REQ_IF=2'd0, REQ_DM=2'd1, REQ_LD=2'd2;
  - the counter width constant.
- One sub-module, mips32_arb_prio: combinational winner select from the three qualified requests and the force-IF flag.

Test Plan:
- Reset with dm_req held high, then release: first dm_gnt appears at the first edge after reset falls. dm_rvalid follows MEM_LAT+1 cycles later, with memory preloaded as word 5 = 32'h28020014 and dm_rdata = 32'h28020014.
- Store then load: DM store 32'h0000001E to address 3, then DM load from address 3. The store returns dm_rvalid with rdata 0; the load returns 32'h0000001E.
- if_req and dm_req held together: grants alternate DM-only until dm_req drops, with IF granted next. With the feature and STARVE_LIMIT=4, IF is granted on the 5th arbitration instead.
- ld_req with cpu_halted=0: never granted. Setting cpu_halted=1 gives ld_gnt at the next IDLE edge, ahead of a pending dm_req.
- Reset asserted during ACCESS of an IF read: all outputs 0 asynchronously. No if_rvalid after release; busy=0.
- MEM_LAT=1 and MEM_LAT=15 builds: rvalid arrives exactly 2 and 16 cycles after gnt respectively.
